// File: rtl/tune_pkg.sv
// Shared types and constants for the tune detector.
// Contents: the note_id encoding, the nominal period of each recognised note in
// 50 MHz clk cycles, the sequence FSM state encoding, the expected-note table
// for each state, and the period-to-note classifier.
package tune_pkg;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        D7   = 3'd1,
        E7   = 3'd2,
        F7   = 3'd3,
        A6   = 3'd4,
        UNK  = 3'd7
    } note_t;

    localparam logic [15:0] PER_D7 = 16'd21285;
    localparam logic [15:0] PER_E7 = 16'd18960;
    localparam logic [15:0] PER_F7 = 16'd17895;
    localparam logic [15:0] PER_A6 = 16'd28409;

    typedef enum logic [2:0] {
        SEQ0 = 3'd0, SEQ1 = 3'd1, SEQ2 = 3'd2, SEQ3 = 3'd3,
        SEQ4 = 3'd4, SEQ5 = 3'd5, SEQ6 = 3'd6, SEQ7 = 3'd7
    } seq_t;

    // Note the FSM is waiting for in each state: D7 E7 F7 E7 F7 D7 A6 D7.
    function automatic note_t expected_note(input seq_t s);
        case (s)
            SEQ0:    return D7;
            SEQ1:    return E7;
            SEQ2:    return F7;
            SEQ3:    return E7;
            SEQ4:    return F7;
            SEQ5:    return D7;
            SEQ6:    return A6;
            SEQ7:    return D7;
            default: return NONE;
        endcase
    endfunction

    // Inclusive window test done in 17 bits so that neither side can wrap.
    function automatic logic in_window(input logic [15:0] p, input logic [15:0] nom,
                                       input logic [15:0] tol);
        return (({1'b0, p} + {1'b0, tol}) >= {1'b0, nom}) &&
               ({1'b0, p} <= ({1'b0, nom} + {1'b0, tol}));
    endfunction

    function automatic note_t classify(input logic [15:0] p, input logic [15:0] tol);
        if (in_window(p, PER_D7, tol)) return D7;
        if (in_window(p, PER_E7, tol)) return E7;
        if (in_window(p, PER_F7, tol)) return F7;
        if (in_window(p, PER_A6, tol)) return A6;
        return UNK;
    endfunction

endpackage

// File: rtl/tone_period_meas.sv
// Period measurement front end for the tune detector.
// Synchronizes the asynchronous tone, finds its rising edges and times the
// distance between them with a saturating 16-bit counter.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   tone_in   - asynchronous square-wave tone
//   meas_vld  - combinational strobe: an armed edge with a valid period
//   period    - counter value; it is the measured period while meas_vld is high
//   timeout   - combinational strobe: counter steps to 16'hFFFF next edge (tone lost)
module tone_period_meas (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic        meas_vld,
    output logic [15:0] period,
    output logic        timeout
);
    import tune_pkg::*;

    logic [1:0]  sync;
    logic        sync_d;
    logic        edge_det;
    logic [15:0] cnt;
    logic        armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= 2'b00;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[0], tone_in};
            sync_d <= sync[1];
        end
    end

    assign edge_det = sync[1] & ~sync_d;

    // The counter reads 1 in the edge cycle, so at the next edge it holds the
    // full period. Saturation at FFFF means the tone is gone: the block
    // disarms, and the next edge only restarts timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 16'hFFFF;
            armed <= 1'b0;
        end else if (edge_det) begin
            cnt   <= 16'd1;
            armed <= 1'b1;
        end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'hFFFE) armed <= 1'b0;
        end
    end

    assign meas_vld = edge_det & armed & (cnt != 16'hFFFF);
    assign period   = cnt;
    assign timeout  = ~edge_det & (cnt == 16'hFFFE);

endmodule

// File: rtl/tune_detect.sv
// Tune detector: recognises the tune D7 E7 F7 E7 F7 D7 A6 D7 on a square-wave
// tone by measuring its period, classifying the period into a note, requiring
// STABLE_CNT consecutive matching periods before a note counts, and stepping a
// sequence FSM on each newly established note.
// Configuration macro: SILENCE_ABORT_EN - when defined, loss of tone sends the
// sequence FSM back to SEQ0; otherwise silence leaves the FSM where it is.
// Ports:
//   clk, rst    - 50 MHz system clock, asynchronous active-high reset
//   tone_in     - asynchronous square-wave tone
//   note_vld    - one-cycle pulse when a new note is established
//   note_id     - last established note (tune_pkg::note_t encoding)
//   note_period - last measured period in clk cycles
//   silence     - high while no tone is present
//   tune_det    - one-cycle pulse, coincident with note_vld, on the full tune
module tune_detect #(
    parameter int          STABLE_CNT = 4,
    parameter logic [15:0] TOL        = 16'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic        note_vld,
    output logic [2:0]  note_id,
    output logic [15:0] note_period,
    output logic        silence,
    output logic        tune_det
);
    import tune_pkg::*;

    localparam int SW = $clog2(STABLE_CNT + 1);

    logic          meas_vld;
    logic          timeout;
    logic [15:0]   period;
    note_t         cls;
    note_t         note_q;
    note_t         prev_cls;
    logic [SW-1:0] stab;
    logic [SW-1:0] stab_nxt;
    logic          est;
    seq_t          state_q;
    seq_t          state_d;
    logic          tune_nxt;

    tone_period_meas u_meas (
        .clk      (clk),
        .rst      (rst),
        .tone_in  (tone_in),
        .meas_vld (meas_vld),
        .period   (period),
        .timeout  (timeout)
    );

    assign cls = classify(period, TOL);

    // Run length of identical classes, saturating at STABLE_CNT.
    always_comb begin
        stab_nxt = SW'(1);
        if (cls == prev_cls)
            stab_nxt = (stab >= SW'(STABLE_CNT)) ? stab : stab + 1'b1;
    end

    // A note is established once the run is long enough; comparing against
    // note_id keeps a sustained note from pulsing again.
    assign est = meas_vld && (cls != UNK) && (stab_nxt == SW'(STABLE_CNT)) &&
                 (cls != note_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_vld    <= 1'b0;
            note_period <= 16'd0;
            silence     <= 1'b1;
            note_q      <= NONE;
            prev_cls    <= NONE;
            stab        <= '0;
        end else begin
            note_vld <= est;
            if (meas_vld) begin
                note_period <= period;
                silence     <= 1'b0;
                stab        <= stab_nxt;
                prev_cls    <= cls;
                if (est) note_q <= cls;
            end else if (timeout) begin
                silence  <= 1'b1;
                stab     <= '0;
                prev_cls <= NONE;
                note_q   <= NONE;
            end
        end
    end

    assign note_id = note_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEQ0;
            tune_det <= 1'b0;
        end else begin
            state_q  <= state_d;
            tune_det <= tune_nxt;
        end
    end

    // Sequence FSM steps on the same strobe that produces note_vld, so
    // tune_det lands in the same cycle as the final note's note_vld.
    always_comb begin
        state_d  = state_q;
        tune_nxt = 1'b0;
        if (est) begin
            if (cls == expected_note(state_q)) begin
                if (state_q == SEQ7) begin
                    tune_nxt = 1'b1;
                    state_d  = SEQ0;
                end else begin
                    state_d = seq_t'(state_q + 3'd1);
                end
            end else begin
                // A wrong note may itself be the start of a new attempt.
                state_d = (cls == D7) ? SEQ1 : SEQ0;
            end
        end
`ifdef SILENCE_ABORT_EN
        else if (timeout) begin
            state_d = SEQ0;
        end
`endif
    end

endmodule

// File: tb/tb_tune_detect.sv
// Directed testbench for tune_detect: square-wave tones of hand-chosen periods
// are played and pulse counts, note_id, note_period, silence and the sequence
// state are compared against hand-computed values.
module tb_tune_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tone_in = 1'b0;
    logic        note_vld;
    logic [2:0]  note_id;
    logic [15:0] note_period;
    logic        silence;
    logic        tune_det;

    int pass_cnt = 0;
    int total    = 0;

    // Pulse bookkeeping, written only by the monitor below.
    int   vld_cnt    = 0;
    int   tune_cnt   = 0;
    int   tune_alone = 0;
    int   consec_bad = 0;
    logic vld_d      = 1'b0;
    logic tune_d     = 1'b0;

    localparam int P_D7 = 21285;
    localparam int P_E7 = 18960;
    localparam int P_F7 = 17895;
    localparam int P_A6 = 28409;

    int tune_per [0:7] = '{P_D7, P_E7, P_F7, P_E7, P_F7, P_D7, P_A6, P_D7};
    int jit      [0:5] = '{200, -200, 0, 150, -150, 100};

    tune_detect dut (
        .clk         (clk),
        .rst         (rst),
        .tone_in     (tone_in),
        .note_vld    (note_vld),
        .note_id     (note_id),
        .note_period (note_period),
        .silence     (silence),
        .tune_det    (tune_det)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (note_vld) vld_cnt++;
        if (tune_det) begin
            tune_cnt++;
            if (!note_vld) tune_alone++;
        end
        if ((note_vld && vld_d) || (tune_det && tune_d)) consec_bad++;
        vld_d  = note_vld;
        tune_d = tune_det;
    end

    task automatic do_reset();
        tone_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // n periods of a 50% square wave; each starts with a rising edge.
    task automatic play(input int per, input int n, input bit use_jit);
        for (int i = 0; i < n; i++) begin
            int p;
            p = per + (use_jit ? jit[i % 6] : 0);
            tone_in = 1'b1;
            repeat (p / 2) @(negedge clk);
            tone_in = 1'b0;
            repeat (p - p / 2) @(negedge clk);
        end
    endtask

    // Final rising edge closes the last period, then the line goes quiet.
    task automatic tone_stop();
        tone_in = 1'b1;
        repeat (100) @(negedge clk);
        tone_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (note_vld !== 1'b0) $display("FAIL reset_note_vld: got %b want 0", note_vld); else pass_cnt++;
        total++; if (tune_det !== 1'b0) $display("FAIL reset_tune_det: got %b want 0", tune_det); else pass_cnt++;
        total++; if (note_id !== 3'd0) $display("FAIL reset_note_id: got %0d want 0", note_id); else pass_cnt++;
        total++; if (note_period !== 16'd0) $display("FAIL reset_period: got %0d want 0", note_period); else pass_cnt++;
        total++; if (silence !== 1'b1) $display("FAIL reset_silence: got %b want 1", silence); else pass_cnt++;
        total++; if (dut.state_q !== 3'd0) $display("FAIL reset_state: got %0d want 0", dut.state_q); else pass_cnt++;
    endtask

    task automatic test_single_note();
        int v0, t0;
        do_reset();
        v0 = vld_cnt; t0 = tune_cnt;
        play(P_D7, 6, 1'b0);
        tone_stop();
        total++; if (vld_cnt - v0 !== 1) $display("FAIL single_vld_count: got %0d want 1", vld_cnt - v0); else pass_cnt++;
        total++; if (note_id !== 3'd1) $display("FAIL single_note_id: got %0d want 1", note_id); else pass_cnt++;
        total++; if (note_period !== 16'd21285) $display("FAIL single_period: got %0d want 21285", note_period); else pass_cnt++;
        total++; if (silence !== 1'b0) $display("FAIL single_silence: got %b want 0", silence); else pass_cnt++;
        total++; if (tune_cnt - t0 !== 0) $display("FAIL single_tune: got %0d want 0", tune_cnt - t0); else pass_cnt++;
    endtask

    task automatic test_full_tune();
        int v0, t0, a0, c0;
        do_reset();
        v0 = vld_cnt; t0 = tune_cnt; a0 = tune_alone; c0 = consec_bad;
        for (int k = 0; k < 7; k++) play(tune_per[k], 6, 1'b1);
        // First D7 edge closes A6's last period; A6 was established earlier.
        total++; if (dut.state_q !== 3'd7) $display("FAIL tune_state7: got %0d want 7", dut.state_q); else pass_cnt++;
        total++; if (tune_cnt - t0 !== 0) $display("FAIL tune_early: got %0d want 0", tune_cnt - t0); else pass_cnt++;
        play(tune_per[7], 6, 1'b1);
        tone_stop();
        total++; if (vld_cnt - v0 !== 8) $display("FAIL tune_vld_count: got %0d want 8", vld_cnt - v0); else pass_cnt++;
        total++; if (tune_cnt - t0 !== 1) $display("FAIL tune_det_count: got %0d want 1", tune_cnt - t0); else pass_cnt++;
        total++; if (tune_alone - a0 !== 0) $display("FAIL tune_coincident: got %0d stray want 0", tune_alone - a0); else pass_cnt++;
        total++; if (consec_bad - c0 !== 0) $display("FAIL tune_consecutive: got %0d want 0", consec_bad - c0); else pass_cnt++;
        total++; if (dut.state_q !== 3'd0) $display("FAIL tune_state_back: got %0d want 0", dut.state_q); else pass_cnt++;
        total++; if (note_period !== 16'd21385) $display("FAIL tune_last_period: got %0d want 21385", note_period); else pass_cnt++;
    endtask

    task automatic test_out_of_window();
        int v0;
        do_reset();
        v0 = vld_cnt;
        play(P_D7, 6, 1'b0);
        play(20000, 10, 1'b0);
        tone_stop();
        total++; if (vld_cnt - v0 !== 1) $display("FAIL unk_vld_count: got %0d want 1", vld_cnt - v0); else pass_cnt++;
        total++; if (note_id !== 3'd1) $display("FAIL unk_note_id: got %0d want 1", note_id); else pass_cnt++;
        total++; if (note_period !== 16'd20000) $display("FAIL unk_period: got %0d want 20000", note_period); else pass_cnt++;
    endtask

    task automatic test_restart();
        int v0, t0;
        do_reset();
        v0 = vld_cnt; t0 = tune_cnt;
        play(P_D7, 6, 1'b0);
        play(P_E7, 6, 1'b0);
        play(P_D7, 6, 1'b0);
        play(P_E7, 1, 1'b0);   // closes the last D7 period
        total++; if (dut.state_q !== 3'd1) $display("FAIL restart_state: got %0d want 1", dut.state_q); else pass_cnt++;
        play(P_E7, 5, 1'b0);
        for (int k = 2; k < 8; k++) play(tune_per[k], 6, 1'b0);
        tone_stop();
        total++; if (tune_cnt - t0 !== 1) $display("FAIL restart_tune: got %0d want 1", tune_cnt - t0); else pass_cnt++;
        total++; if (vld_cnt - v0 !== 10) $display("FAIL restart_vld_count: got %0d want 10", vld_cnt - v0); else pass_cnt++;
    endtask

    task automatic test_silence();
        int t0;
        int exp_state, exp_tune;
`ifdef SILENCE_ABORT_EN
        exp_state = 0; exp_tune = 0;
`else
        exp_state = 3; exp_tune = 1;
`endif
        do_reset();
        for (int k = 0; k < 3; k++) play(tune_per[k], 6, 1'b0);
        tone_stop();
        total++; if (silence !== 1'b0) $display("FAIL silence_before: got %b want 0", silence); else pass_cnt++;
        repeat (66000) @(negedge clk);
        total++; if (silence !== 1'b1) $display("FAIL silence_set: got %b want 1", silence); else pass_cnt++;
        total++; if (note_id !== 3'd0) $display("FAIL silence_note_id: got %0d want 0", note_id); else pass_cnt++;
        total++; if (dut.state_q !== 3'(exp_state)) $display("FAIL silence_state: got %0d want %0d", dut.state_q, exp_state); else pass_cnt++;
        t0 = tune_cnt;
        for (int k = 3; k < 8; k++) play(tune_per[k], 6, 1'b0);
        tone_stop();
        total++; if (tune_cnt - t0 !== exp_tune) $display("FAIL silence_resume_tune: got %0d want %0d", tune_cnt - t0, exp_tune); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int v0, t0;
        do_reset();
        for (int k = 0; k < 6; k++) play(tune_per[k], 6, 1'b0);
        play(P_A6, 3, 1'b0);
        total++; if (dut.state_q !== 3'd6) $display("FAIL mid_state_before: got %0d want 6", dut.state_q); else pass_cnt++;
        #3 rst = 1'b1;
        #1;
        total++; if (note_id !== 3'd0) $display("FAIL mid_note_id: got %0d want 0", note_id); else pass_cnt++;
        total++; if (silence !== 1'b1) $display("FAIL mid_silence: got %b want 1", silence); else pass_cnt++;
        total++; if (note_period !== 16'd0) $display("FAIL mid_period: got %0d want 0", note_period); else pass_cnt++;
        total++; if ((note_vld | tune_det) !== 1'b0) $display("FAIL mid_pulses: got %b%b want 00", note_vld, tune_det); else pass_cnt++;
        total++; if (dut.state_q !== 3'd0) $display("FAIL mid_state: got %0d want 0", dut.state_q); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        v0 = vld_cnt; t0 = tune_cnt;
        play(P_D7, 6, 1'b0);
        tone_stop();
        total++; if (tune_cnt - t0 !== 0) $display("FAIL mid_no_tune: got %0d want 0", tune_cnt - t0); else pass_cnt++;
        total++; if (vld_cnt - v0 !== 1) $display("FAIL mid_vld_count: got %0d want 1", vld_cnt - v0); else pass_cnt++;
        total++; if (dut.state_q !== 3'd1) $display("FAIL mid_state_after: got %0d want 1", dut.state_q); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_full_tune();
        test_out_of_window();
        test_restart();
        test_silence();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
